// File: rtl/mips_ex_lsu_ctrl_pkg.sv
// Shared encodings for the EX-stage load/store sequencer: FSM states and
// access-size codes as produced by the AGU decode.
package mips_ex_lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    MIPS_LSU_ST_IDLE  = 2'd0,
    MIPS_LSU_ST_REQ   = 2'd1,
    MIPS_LSU_ST_RESP  = 2'd2,
    MIPS_LSU_ST_DRAIN = 2'd3
  } lsu_state_e;

  localparam logic [1:0] MIPS_LSU_SIZE_B = 2'b00;
  localparam logic [1:0] MIPS_LSU_SIZE_H = 2'b01;
  localparam logic [1:0] MIPS_LSU_SIZE_W = 2'b10;

endpackage

// File: rtl/mips_lsu_align.sv
// Combinational lane logic: alignment check, byte enables and write-lane
// replication on the request side; load extraction and extension on the response side.
module mips_lsu_align
  import mips_ex_lsu_ctrl_pkg::*;
(
  input  logic [1:0]  req_off_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_wdat_i,
  output logic        misalign_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdat_o,
  input  logic [1:0]  rsp_off_i,
  input  logic [1:0]  rsp_size_i,
  input  logic        rsp_usign_i,
  input  logic [31:0] rsp_rdat_i,
  output logic [31:0] rsp_data_o
);

  logic [31:0] shifted;

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    misalign_o = 1'b0;
    be_o       = 4'b1111;
    wdat_o     = req_wdat_i;
    unique case (req_size_i)
      MIPS_LSU_SIZE_B: begin
        be_o   = 4'b0001 << req_off_i;
        wdat_o = {4{req_wdat_i[7:0]}};
      end
      MIPS_LSU_SIZE_H: begin
        misalign_o = req_off_i[0];
        be_o       = 4'b0011 << {req_off_i[1], 1'b0};
        wdat_o     = {2{req_wdat_i[15:0]}};
      end
      MIPS_LSU_SIZE_W: misalign_o = |req_off_i;
      default:         misalign_o = 1'b1;
    endcase
  end

  assign shifted = rsp_rdat_i >> {rsp_off_i, 3'b000};

  always_comb begin
    rsp_data_o = shifted;
    unique case (rsp_size_i)
      MIPS_LSU_SIZE_B:
        rsp_data_o = rsp_usign_i ? {24'd0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      MIPS_LSU_SIZE_H:
        rsp_data_o = rsp_usign_i ? {16'd0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      default: rsp_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mips_ex_lsu_ctrl.sv
// EX-stage load/store sequencer: one transaction at a time over a req/gnt/rvalid
// data bus, with pipeline stall, alignment exceptions and flush of in-flight ops.
module mips_ex_lsu_ctrl
  import mips_ex_lsu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_valid,
  input  logic                  lsu_read,
  input  logic                  lsu_write,
  input  logic [DATA_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdat,
  input  logic [1:0]            lsu_size,
  input  logic                  lsu_usign,
  input  logic [RD_WIDTH-1:0]   lsu_rd,
  input  logic                  lsu_flush,
  output logic                  lsu_stall,
  output logic                  lsu_done,
  output logic [DATA_WIDTH-1:0] lsu_rdat,
  output logic [RD_WIDTH-1:0]   lsu_rd_o,
  output logic                  lsu_wen,
  output logic                  lsu_misalign,
  output logic [DATA_WIDTH-1:0] lsu_badaddr,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdat,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdat
);

  lsu_state_e state_q, state_d;

  logic                  start, misalign, start_aligned;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdat_lane, rdat_ext;
  logic                  req_d, done_d, wen_d, misalign_d, capture, rdat_cap;

  logic                  req_q, we_q, done_q, wen_q, misalign_q, usign_q;
  logic [DATA_WIDTH-1:0] addr_q, wdat_q, rdat_q, badaddr_q;
  logic [3:0]            be_q;
  logic [1:0]            off_q, size_q;
  logic [RD_WIDTH-1:0]   rd_q, rd_o_q;

  mips_lsu_align u_align (
    .req_off_i   (lsu_addr[1:0]),
    .req_size_i  (lsu_size),
    .req_wdat_i  (lsu_wdat),
    .misalign_o  (misalign),
    .be_o        (be),
    .wdat_o      (wdat_lane),
    .rsp_off_i   (off_q),
    .rsp_size_i  (size_q),
    .rsp_usign_i (usign_q),
    .rsp_rdat_i  (dmem_rdat),
    .rsp_data_o  (rdat_ext)
  );

  assign start         = (state_q == MIPS_LSU_ST_IDLE) & lsu_valid
                         & (lsu_read | lsu_write) & ~lsu_flush;
  assign start_aligned = start & ~misalign;

  always_comb begin
    state_d    = state_q;
    req_d      = 1'b0;
    done_d     = 1'b0;
    wen_d      = 1'b0;
    misalign_d = 1'b0;
    capture    = 1'b0;
    rdat_cap   = 1'b0;
    unique case (state_q)
      MIPS_LSU_ST_IDLE: begin
        if (start && misalign) begin
          misalign_d = 1'b1;
        end else if (start) begin
          capture = 1'b1;
          req_d   = 1'b1;
          state_d = MIPS_LSU_ST_REQ;
        end
      end
      MIPS_LSU_ST_REQ: begin
        // A granted transfer is committed even under flush; only its result is dropped.
        if (dmem_gnt) begin
          if (we_q) begin
            state_d = MIPS_LSU_ST_IDLE;
            done_d  = ~lsu_flush;
          end else begin
            state_d = lsu_flush ? MIPS_LSU_ST_DRAIN : MIPS_LSU_ST_RESP;
          end
        end else if (lsu_flush) begin
          state_d = MIPS_LSU_ST_IDLE;
        end else begin
          req_d = 1'b1;
        end
      end
      MIPS_LSU_ST_RESP: begin
        if (dmem_rvalid) begin
          state_d = MIPS_LSU_ST_IDLE;
          if (!lsu_flush) begin
            done_d   = 1'b1;
            wen_d    = 1'b1;
            rdat_cap = 1'b1;
          end
        end else if (lsu_flush) begin
          state_d = MIPS_LSU_ST_DRAIN;
        end
      end
      MIPS_LSU_ST_DRAIN: begin
        if (dmem_rvalid) state_d = MIPS_LSU_ST_IDLE;
      end
      default: state_d = MIPS_LSU_ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MIPS_LSU_ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      wen_q      <= 1'b0;
      misalign_q <= 1'b0;
      usign_q    <= 1'b0;
      addr_q     <= '0;
      wdat_q     <= '0;
      rdat_q     <= '0;
      badaddr_q  <= '0;
      be_q       <= '0;
      off_q      <= '0;
      size_q     <= '0;
      rd_q       <= '0;
      rd_o_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      done_q     <= done_d;
      wen_q      <= wen_d;
      misalign_q <= misalign_d;
      if (misalign_d) badaddr_q <= lsu_addr;
      if (capture) begin
        we_q    <= lsu_write;
        addr_q  <= {lsu_addr[DATA_WIDTH-1:2], 2'b00};
        be_q    <= be;
        wdat_q  <= wdat_lane;
        off_q   <= lsu_addr[1:0];
        size_q  <= lsu_size;
        usign_q <= lsu_usign;
        rd_q    <= lsu_rd;
      end
      if (rdat_cap) begin
        rdat_q <= rdat_ext;
        rd_o_q <= rd_q;
      end
    end
  end

  assign lsu_stall    = start_aligned | (state_q != MIPS_LSU_ST_IDLE);
  assign lsu_done     = done_q;
  assign lsu_rdat     = rdat_q;
  assign lsu_rd_o     = rd_o_q;
  assign lsu_wen      = wen_q;
  assign lsu_misalign = misalign_q;
  assign lsu_badaddr  = badaddr_q;
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdat    = wdat_q;

endmodule
